// File: rtl/batalha_naval_pkg.sv
// rtl/batalha_naval_pkg.sv - shared types, constants and ship-vector packing for Batalha Naval
package batalha_naval_pkg;

    localparam int COORD_W       = 4;
    localparam int CELL_W        = 8;
    localparam int CELL_BASE     = 3;
    localparam int GRID_SIZE_DEF = 10;
    localparam int MAX_SHIP_LEN  = 7;

    localparam int N_BOTOES    = 6;
    localparam int BTN_LEFT    = 0;
    localparam int BTN_RIGHT   = 1;
    localparam int BTN_UP      = 2;
    localparam int BTN_DOWN    = 3;
    localparam int BTN_ROTATE  = 4;
    localparam int BTN_CONFIRM = 5;

    typedef enum logic [1:0] {
        S_EDIT   = 2'd0,
        S_COMMIT = 2'd1,
        S_LOCKED = 2'd2
    } estado_t;

    typedef struct packed {
        logic [COORD_W-1:0] y;
        logic [COORD_W-1:0] x;
    } coord_t;

    // Cell k sits at anchor + k along the orientation axis; unused cells stay zero.
    function automatic logic [63:0] pack_posicoes(
        input coord_t anchor,
        input logic   orientacao,
        input int     len
    );
        logic [63:0]        v;
        logic [COORD_W-1:0] cx;
        logic [COORD_W-1:0] cy;
        v = '0;
        for (int k = 0; k < MAX_SHIP_LEN; k++) begin
            if (k < len) begin
                cx = anchor.x + (orientacao ? COORD_W'(0) : COORD_W'(k));
                cy = anchor.y + (orientacao ? COORD_W'(k) : COORD_W'(0));
                v[CELL_BASE + CELL_W*k +: CELL_W] = {cy, cx};
            end
        end
        return v;
    endfunction

endpackage

// File: rtl/debounce_botao.sv
// rtl/debounce_botao.sv - button synchronizer, debouncer and rising-edge pulse
module debounce_botao #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic botao,
    output logic pulso
);

    localparam int               CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_a;
    logic             sync_b;
    logic             nivel;
    logic             nivel_d;
    logic [CNT_W-1:0] cnt;

    // The counter only runs while the synchronized input disagrees with the accepted level.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_a  <= 1'b0;
            sync_b  <= 1'b0;
            nivel   <= 1'b0;
            nivel_d <= 1'b0;
            cnt     <= '0;
        end else begin
            sync_a  <= botao;
            sync_b  <= sync_a;
            nivel_d <= nivel;
            if (sync_b == nivel) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                cnt   <= '0;
                nivel <= sync_b;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    assign pulso = nivel & ~nivel_d;

endmodule

// File: rtl/embarcacao_posicionamento_ctrl.sv
// rtl/embarcacao_posicionamento_ctrl.sv - interactive ship placement with commit handshake
module embarcacao_posicionamento_ctrl
    import batalha_naval_pkg::*;
#(
    parameter int SHIP_LEN        = 3,
    parameter int GRID_SIZE       = GRID_SIZE_DEF,
    parameter int INIT_X          = 5,
    parameter int INIT_Y          = 5,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        leftArrow,
    input  logic        rightArrow,
    input  logic        upArrow,
    input  logic        downArrow,
    input  logic        rotate,
    input  logic        confirm,
    input  logic        novo_posicionamento,
    input  logic        commit_ready,
    output logic [63:0] posicoesEmbarcacao,
    output logic        orientacao,
    output logic        commit_valid,
    output logic        editando
);

    localparam int EXT_W = COORD_W + 1;
    typedef logic [EXT_W-1:0] ext_t;

    localparam ext_t        GRID_EXT  = ext_t'(GRID_SIZE);
    localparam ext_t        LEN_M1    = ext_t'(SHIP_LEN - 1);
    localparam coord_t      INIT_POS  = '{y: COORD_W'(INIT_Y), x: COORD_W'(INIT_X)};
    localparam logic [63:0] POS_RESET = pack_posicoes(INIT_POS, 1'b0, SHIP_LEN);

    logic [N_BOTOES-1:0] botoes;
    logic [N_BOTOES-1:0] pulsos;
    logic [4:0]          movimentos;

    estado_t state;
    estado_t state_n;
    coord_t  anchor;
    coord_t  anchor_n;
    logic    orient_n;

    ext_t cand_x;
    ext_t cand_y;
    ext_t tip_x;
    ext_t tip_y;
    logic cand_o;
    logic cabe;

    assign botoes = {confirm, rotate, downArrow, upArrow, rightArrow, leftArrow};

    for (genvar i = 0; i < N_BOTOES; i++) begin : g_deb
        debounce_botao #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk    (clk),
            .reset_n(reset_n),
            .botao  (botoes[i]),
            .pulso  (pulsos[i])
        );
    end

    assign movimentos = pulsos[BTN_ROTATE:BTN_LEFT];

    // Candidate placement in 5 bits: 0-1 becomes 31, which the bound check rejects.
    always_comb begin
        cand_x = {1'b0, anchor.x};
        cand_y = {1'b0, anchor.y};
        cand_o = orientacao;
        if (pulsos[BTN_LEFT])   cand_x = cand_x - ext_t'(1);
        if (pulsos[BTN_RIGHT])  cand_x = cand_x + ext_t'(1);
        if (pulsos[BTN_UP])     cand_y = cand_y + ext_t'(1);
        if (pulsos[BTN_DOWN])   cand_y = cand_y - ext_t'(1);
        if (pulsos[BTN_ROTATE]) cand_o = ~cand_o;
        tip_x = cand_x + (cand_o ? ext_t'(0) : LEN_M1);
        tip_y = cand_y + (cand_o ? LEN_M1 : ext_t'(0));
        cabe  = (cand_x < GRID_EXT) && (cand_y < GRID_EXT) &&
                (tip_x < GRID_EXT) && (tip_y < GRID_EXT);
    end

    always_comb begin
        state_n  = state;
        anchor_n = anchor;
        orient_n = orientacao;
        case (state)
            S_EDIT: begin
                if (pulsos[BTN_CONFIRM]) begin
                    state_n = S_COMMIT;
                end else if ($onehot(movimentos) && cabe) begin
                    anchor_n.x = cand_x[COORD_W-1:0];
                    anchor_n.y = cand_y[COORD_W-1:0];
                    orient_n   = cand_o;
                end
            end
            S_COMMIT: begin
                if (commit_ready) state_n = S_LOCKED;
            end
            S_LOCKED: begin
                if (novo_posicionamento) begin
                    state_n  = S_EDIT;
                    anchor_n = INIT_POS;
                    orient_n = 1'b0;
                end
            end
            default: state_n = S_EDIT;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state              <= S_EDIT;
            anchor             <= INIT_POS;
            orientacao         <= 1'b0;
            posicoesEmbarcacao <= POS_RESET;
        end else begin
            state              <= state_n;
            anchor             <= anchor_n;
            orientacao         <= orient_n;
            posicoesEmbarcacao <= pack_posicoes(anchor_n, orient_n, SHIP_LEN);
        end
    end

    assign commit_valid = (state == S_COMMIT);
    assign editando     = (state == S_EDIT);

endmodule

// File: tb/tb_embarcacao_posicionamento_ctrl.sv
// tb/tb_embarcacao_posicionamento_ctrl.sv - randomized and directed bench with behavioural model
module tb_embarcacao_posicionamento_ctrl;

    localparam int L  = 3;
    localparam int G  = 10;
    localparam int N  = 4;
    localparam int IX = 5;
    localparam int IY = 5;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        leftArrow = 1'b0;
    logic        rightArrow = 1'b0;
    logic        upArrow = 1'b0;
    logic        downArrow = 1'b0;
    logic        rotate = 1'b0;
    logic        confirm = 1'b0;
    logic        novo_posicionamento = 1'b0;
    logic        commit_ready = 1'b0;
    logic [63:0] posicoesEmbarcacao;
    logic        orientacao;
    logic        commit_valid;
    logic        editando;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    embarcacao_posicionamento_ctrl #(
        .SHIP_LEN(L), .GRID_SIZE(G), .INIT_X(IX), .INIT_Y(IY), .DEBOUNCE_CYCLES(N)
    ) dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .leftArrow          (leftArrow),
        .rightArrow         (rightArrow),
        .upArrow            (upArrow),
        .downArrow          (downArrow),
        .rotate             (rotate),
        .confirm            (confirm),
        .novo_posicionamento(novo_posicionamento),
        .commit_ready       (commit_ready),
        .posicoesEmbarcacao (posicoesEmbarcacao),
        .orientacao         (orientacao),
        .commit_valid       (commit_valid),
        .editando           (editando)
    );

    // Model state: anchor, orientation, mode (0 edit, 1 commit, 2 locked), button histories.
    int         m_x = IX;
    int         m_y = IY;
    int         m_o = 0;
    int         m_mode = 0;
    logic [5:0] m_pulse = '0;
    logic [5:0] m_lvl = '0;
    logic [5:0] m_r1 = '0;
    logic [5:0] m_r2 = '0;
    logic [5:0] m_hist [N];

    function automatic bit fits(int x, int y, int o);
        return x >= 0 && y >= 0 && (x + (o == 0 ? L - 1 : 0)) < G && (y + (o == 1 ? L - 1 : 0)) < G;
    endfunction

    function automatic logic [63:0] expect_vec(int x, int y, int o);
        logic [63:0] v;
        int cx;
        int cy;
        v = '0;
        for (int k = 0; k < L; k++) begin
            cx = x + (o == 0 ? k : 0);
            cy = y + (o == 1 ? k : 0);
            v = v | (64'(cy * 16 + cx) << (3 + 8 * k));
        end
        return v;
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge reset_n) begin
        logic [5:0] raw;
        logic [5:0] newp;
        int         nx, ny, no;
        bit         all_diff;
        if (!reset_n) begin
            m_x = IX; m_y = IY; m_o = 0; m_mode = 0;
            m_pulse = '0; m_lvl = '0; m_r1 = '0; m_r2 = '0;
            for (int j = 0; j < N; j++) m_hist[j] = '0;
        end else begin
            case (m_mode)
                0: begin
                    if (m_pulse[5]) begin
                        m_mode = 1;
                    end else if ($countones(m_pulse[4:0]) == 1) begin
                        nx = m_x; ny = m_y; no = m_o;
                        if (m_pulse[0]) nx = nx - 1;
                        if (m_pulse[1]) nx = nx + 1;
                        if (m_pulse[2]) ny = ny + 1;
                        if (m_pulse[3]) ny = ny - 1;
                        if (m_pulse[4]) no = 1 - no;
                        if (fits(nx, ny, no)) begin
                            m_x = nx; m_y = ny; m_o = no;
                        end
                    end
                end
                1: if (commit_ready) m_mode = 2;
                default: if (novo_posicionamento) begin
                    m_x = IX; m_y = IY; m_o = 0; m_mode = 0;
                end
            endcase
            raw = {confirm, rotate, downArrow, upArrow, rightArrow, leftArrow};
            for (int j = N - 1; j > 0; j--) m_hist[j] = m_hist[j-1];
            m_hist[0] = m_r2;
            m_r2 = m_r1;
            m_r1 = raw;
            newp = '0;
            // A level is accepted once the last N synchronized samples all disagree with it.
            for (int b = 0; b < 6; b++) begin
                all_diff = 1'b1;
                for (int j = 0; j < N; j++) if (m_hist[j][b] == m_lvl[b]) all_diff = 1'b0;
                if (all_diff) begin
                    m_lvl[b] = ~m_lvl[b];
                    newp[b]  = m_lvl[b];
                end
            end
            m_pulse = newp;
        end
    end

    always @(negedge clk) begin
        check("vector", posicoesEmbarcacao, expect_vec(m_x, m_y, m_o));
        check("orientacao", 64'(orientacao), 64'(m_o));
        check("commit_valid", 64'(commit_valid), 64'(m_mode == 1));
        check("editando", 64'(editando), 64'(m_mode == 0));
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic set_btn(input int b, input logic v);
        case (b)
            0: leftArrow = v;
            1: rightArrow = v;
            2: upArrow = v;
            3: downArrow = v;
            4: rotate = v;
            default: confirm = v;
        endcase
    endtask

    task automatic press(input int b);
        set_btn(b, 1'b1);
        tick(8);
        set_btn(b, 1'b0);
        tick(10);
    endtask

    task automatic press2(input int a, input int b);
        set_btn(a, 1'b1);
        set_btn(b, 1'b1);
        tick(8);
        set_btn(a, 1'b0);
        set_btn(b, 1'b0);
        tick(10);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick(2);
        reset_n = 1'b1;
        tick(2);
    endtask

    initial begin
        tick(3);
        reset_n = 1'b1;
        tick(2);
        #4;
        check("t1_vec", posicoesEmbarcacao, 64'h0000_0000_02BA_B2A8);
        check("t1_orient", 64'(orientacao), 64'd0);
        check("t1_edit", 64'(editando), 64'd1);
        check("t1_valid", 64'(commit_valid), 64'd0);

        tick(1);
        press(1); press(1); press(1);
        #4;
        check("t2_right_edge", posicoesEmbarcacao, 64'h0000_0000_02CA_C2B8);
        set_btn(1, 1'b1); tick(3); set_btn(1, 1'b0); tick(10);
        #4;
        check("t2_glitch", posicoesEmbarcacao, 64'h0000_0000_02CA_C2B8);

        do_reset();
        press(2); press(2); press(2); press(4);
        #4;
        check("t3_rot_rej_vec", posicoesEmbarcacao, 64'h0000_0000_043C_3428);
        check("t3_rot_rej_or", 64'(orientacao), 64'd0);
        press(3); press(4);
        #4;
        check("t3_rot_vec", posicoesEmbarcacao, 64'h0000_0000_04AC_2BA8);
        check("t3_rot_or", 64'(orientacao), 64'd1);

        do_reset();
        press2(0, 2);
        #4;
        check("t4_simul", posicoesEmbarcacao, 64'h0000_0000_02BA_B2A8);
        press2(0, 5);
        #4;
        check("t4_conf_vec", posicoesEmbarcacao, 64'h0000_0000_02BA_B2A8);
        check("t4_conf_valid", 64'(commit_valid), 64'd1);

        tick(5);
        press(1);
        novo_posicionamento = 1'b1; tick(1); novo_posicionamento = 1'b0;
        #4;
        check("t5_hold_vec", posicoesEmbarcacao, 64'h0000_0000_02BA_B2A8);
        check("t5_hold_valid", 64'(commit_valid), 64'd1);
        commit_ready = 1'b1; tick(1); commit_ready = 1'b0;
        #4;
        check("t5_done_valid", 64'(commit_valid), 64'd0);
        check("t5_done_edit", 64'(editando), 64'd0);
        press(0);
        #4;
        check("t5_lock_vec", posicoesEmbarcacao, 64'h0000_0000_02BA_B2A8);
        novo_posicionamento = 1'b1; tick(1); novo_posicionamento = 1'b0;
        #4;
        check("t5_novo_edit", 64'(editando), 64'd1);

        tick(1);
        press(2);
        press(5);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("t6_async_valid", 64'(commit_valid), 64'd0);
        check("t6_async_vec", posicoesEmbarcacao, 64'h0000_0000_02BA_B2A8);
        check("t6_async_edit", 64'(editando), 64'd1);
        tick(2);
        reset_n = 1'b1;
        tick(2);

        for (int c = 0; c < 4000; c++) begin
            for (int b = 0; b < 6; b++) begin
                if ($urandom_range(0, 11) == 0) begin
                    case (b)
                        0: leftArrow = ~leftArrow;
                        1: rightArrow = ~rightArrow;
                        2: upArrow = ~upArrow;
                        3: downArrow = ~downArrow;
                        4: rotate = ~rotate;
                        default: confirm = ~confirm;
                    endcase
                end
            end
            commit_ready = ($urandom_range(0, 2) == 0);
            novo_posicionamento = ($urandom_range(0, 7) == 0);
            tick(1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
